// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read, dual-write register file with
// per-register busy scoreboard and a sequential clear engine.
//
// Ports:
//   clk, clrn          clock (rising edge), async active-high reset
//   ra / qa / rbusy    NR combinational read ports (address, data, busy bit)
//   we0/wa0/wd0        write port 0
//   we1/wa1/wd1        write port 1, wins over port 0 on an address clash
//   iss_en/iss_rd      issue strobe: marks iss_rd busy
//   sclr               starts the clear engine (one entry per cycle)
//   clr_busy           high while the clear engine runs
module regfile_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NR       = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [NR*AW-1:0] ra,
    output logic [NR*DW-1:0] qa,
    output logic [NR-1:0]    rbusy,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic [DW-1:0]    wd0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic [DW-1:0]    wd1,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_rd,
    input  logic             sclr,
    output logic             clr_busy
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            cnt_q, cnt_d;
    logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]         busy_q, busy_d;

    logic idle;
    logic w0_ok, w1_ok, iss_ok;

    // Register 0 is hard-wired when ZERO_REG is set.
    function automatic logic is_zr(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign idle     = (state_q == IDLE);
    assign clr_busy = (state_q == CLEAR);

    // Qualified write/issue strobes: only in IDLE, never to a hard-wired r0.
    assign w0_ok  = idle && we0    && !is_zr(wa0);
    assign w1_ok  = idle && we1    && !is_zr(wa1);
    assign iss_ok = idle && iss_en && !is_zr(iss_rd);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                // Port 1 is applied last so it wins on an address clash.
                if (w0_ok) begin
                    mem_d[wa0]  = wd0;
                    busy_d[wa0] = 1'b0;
                end
                if (w1_ok) begin
                    mem_d[wa1]  = wd1;
                    busy_d[wa1] = 1'b0;
                end
                // Set after clear: a newly issued producer keeps the reg busy.
                if (iss_ok) busy_d[iss_rd] = 1'b1;
                if (sclr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                mem_d[cnt_q]  = '0;
                busy_d[cnt_q] = 1'b0;
                cnt_d         = cnt_q + 1'b1;   // wraps to 0 after the last entry
                if (&cnt_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mem_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
            busy_q  <= busy_d;
        end
    end

    // Read ports. Bypass uses the qualified strobes, so it is inherently
    // disabled during CLEAR and never forwards a dropped r0 write.
    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        assign a = ra[i*AW +: AW];

        always_comb begin
            d = mem_q[a];
            if (BYPASS != 0) begin
                if (w1_ok && (wa1 == a))      d = wd1;
                else if (w0_ok && (wa0 == a)) d = wd0;
            end
            if (is_zr(a)) d = '0;
        end

        assign qa[i*DW +: DW] = d;
        // Registered busy only: a same-cycle write does not hide the hazard.
        assign rbusy[i]       = busy_q[a] & ~is_zr(a);
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    // Main DUTs (32x32, NR=2): bypass and no-bypass share all inputs.
    logic [9:0]  ra;
    logic [63:0] qa, qa_nb;
    logic [1:0]  rbusy, rbusy_nb;
    logic        we0, we1, iss_en, sclr;
    logic [4:0]  wa0, wa1, iss_rd;
    logic [31:0] wd0, wd1;
    logic        clr_busy, clr_busy_nb;

    // Sweep DUT (DW=64, AW=4, NR=4).
    logic [15:0]  s_ra;
    logic [255:0] s_qa;
    logic [3:0]   s_rbusy;
    logic         s_we0, s_we1, s_iss, s_sclr, s_clr_busy;
    logic [3:0]   s_wa0, s_wa1, s_rd;
    logic [63:0]  s_wd0, s_wd1;

    regfile_mp #(.DW(32), .AW(5), .NR(2), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .clrn(clrn), .ra(ra), .qa(qa), .rbusy(rbusy),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_en), .iss_rd(iss_rd), .sclr(sclr), .clr_busy(clr_busy));

    regfile_mp #(.DW(32), .AW(5), .NR(2), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .clrn(clrn), .ra(ra), .qa(qa_nb), .rbusy(rbusy_nb),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_en), .iss_rd(iss_rd), .sclr(sclr), .clr_busy(clr_busy_nb));

    regfile_mp #(.DW(64), .AW(4), .NR(4), .BYPASS(1), .ZERO_REG(1)) dut_sw (
        .clk(clk), .clrn(clrn), .ra(s_ra), .qa(s_qa), .rbusy(s_rbusy),
        .we0(s_we0), .wa0(s_wa0), .wd0(s_wd0), .we1(s_we1), .wa1(s_wa1), .wd1(s_wd1),
        .iss_en(s_iss), .iss_rd(s_rd), .sclr(s_sclr), .clr_busy(s_clr_busy));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (main 32x32 file) ----------------
    logic [31:0] m [32];
    bit          mb[32];
    bit          mclr;
    int          mcnt;

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin m[i] = '0; mb[i] = 1'b0; end
        mclr = 1'b0;
        mcnt = 0;
    endtask

    function automatic logic [31:0] eq(input int a, input bit byp);
        if (a == 0) return '0;
        if (byp && !mclr) begin
            if (we1 && int'(wa1) == a) return wd1;
            if (we0 && int'(wa0) == a) return wd0;
        end
        return m[a];
    endfunction

    function automatic bit eb(input int a);
        return (a == 0) ? 1'b0 : mb[a];
    endfunction

    // Applies one rising edge worth of architectural effect.
    task automatic m_edge();
        if (!mclr) begin
            if (we0 && wa0 != 0) begin m[wa0] = wd0; mb[wa0] = 1'b0; end
            if (we1 && wa1 != 0) begin m[wa1] = wd1; mb[wa1] = 1'b0; end
            if (iss_en && iss_rd != 0) mb[iss_rd] = 1'b1;
            if (sclr) begin mclr = 1'b1; mcnt = 0; end
        end else begin
            m[mcnt]  = '0;
            mb[mcnt] = 1'b0;
            if (mcnt == 31) mclr = 1'b0;
            mcnt = (mcnt + 1) % 32;
        end
    endtask

    task automatic check_main(input string tag);
        for (int p = 0; p < 2; p++) begin
            int a;
            a = int'(ra[p*5 +: 5]);
            chk({tag, " qa"},       64'(qa[p*32 +: 32]),    64'(eq(a, 1'b1)));
            chk({tag, " qa_nb"},    64'(qa_nb[p*32 +: 32]), 64'(eq(a, 1'b0)));
            chk({tag, " rbusy"},    64'(rbusy[p]),          64'(eb(a)));
            chk({tag, " rbusy_nb"}, 64'(rbusy_nb[p]),       64'(eb(a)));
        end
        chk({tag, " clr_busy"},    64'(clr_busy),    64'(mclr));
        chk({tag, " clr_busy_nb"}, 64'(clr_busy_nb), 64'(mclr));
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        check_main(tag);
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle_in();
        we0 = 0; wa0 = 0; wd0 = 0; we1 = 0; wa1 = 0; wd1 = 0;
        iss_en = 0; iss_rd = 0; sclr = 0;
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < 32; a += 2) begin
            ra = {5'(a + 1), 5'(a)};
            step(tag);
        end
    endtask

    // Pulses sclr, then counts cycles with clr_busy high (bounded).
    // At cycle inj, writes/issue/sclr are driven and must be ignored.
    task automatic run_clear(input string tag, input int inj, output int n);
        sclr = 1; ra = {5'd3, 5'd4};
        step({tag, " sclr"});
        sclr = 0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            idle_in();
            if (k == inj) begin
                we0 = 1; wa0 = 3; wd0 = 32'h99; iss_en = 1; iss_rd = 4; sclr = 1;
            end
            ra = {5'($urandom_range(0, 31)), 5'(k % 32)};
            @(negedge clk);
            check_main(tag);
            if (!clr_busy) break;
            n++;
            @(posedge clk);
            m_edge();
            #1;
        end
        idle_in();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        we0; logic [4:0] wa0; logic [31:0] wd0;
        logic        we1; logic [4:0] wa1; logic [31:0] wd1;
        logic        iss; logic [4:0] rd;
        logic [4:0]  ra0, ra1;
        logic [31:0] q0, q1, q0nb, q1nb;
        logic        b0, b1;
    } vec_t;

    vec_t tbl[12];
    int   n;
    logic [63:0] sv[5];

    initial begin
        tbl[0]  = '{1, 0, 32'hDEADBEEF, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 7, 32'h11111111, 1, 7, 32'h22222222, 0, 0, 7, 0, 32'h22222222, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0,            0, 0, 0,           0, 0, 7, 0, 32'h22222222, 0, 32'h22222222, 0, 0, 0};
        tbl[3]  = '{1, 7, 32'h33333333, 0, 0, 0,           0, 0, 7, 7, 32'h33333333, 32'h33333333, 32'h22222222, 32'h22222222, 0, 0};
        tbl[4]  = '{0, 0, 0,            0, 0, 0,           1, 5, 5, 7, 0, 32'h33333333, 0, 32'h33333333, 0, 0};
        tbl[5]  = '{0, 0, 0,            0, 0, 0,           0, 0, 5, 7, 0, 32'h33333333, 0, 32'h33333333, 1, 0};
        tbl[6]  = '{1, 5, 32'h55,       0, 0, 0,           0, 0, 5, 7, 32'h55, 32'h33333333, 0, 32'h33333333, 1, 0};
        tbl[7]  = '{0, 0, 0,            0, 0, 0,           0, 0, 5, 7, 32'h55, 32'h33333333, 32'h55, 32'h33333333, 0, 0};
        tbl[8]  = '{0, 0, 0,            1, 5, 32'hAA,      1, 5, 5, 7, 32'hAA, 32'h33333333, 32'h55, 32'h33333333, 0, 0};
        tbl[9]  = '{0, 0, 0,            0, 0, 0,           0, 0, 5, 7, 32'hAA, 32'h33333333, 32'hAA, 32'h33333333, 1, 0};
        tbl[10] = '{0, 0, 0,            1, 0, 32'h1234,    1, 0, 0, 5, 0, 32'hAA, 0, 32'hAA, 0, 1};
        tbl[11] = '{0, 0, 0,            0, 0, 0,           0, 0, 0, 5, 0, 32'hAA, 0, 32'hAA, 0, 1};

        idle_in(); ra = 0;
        s_we0 = 0; s_we1 = 0; s_iss = 0; s_sclr = 0; s_wa0 = 0; s_wa1 = 0; s_rd = 0;
        s_wd0 = 0; s_wd1 = 0; s_ra = 0;
        clrn = 1;
        m_reset();
        #12;
        check_main("reset");
        chk("sw reset clr_busy", 64'(s_clr_busy), 64'd0);
        @(negedge clk); clrn = 0;
        @(posedge clk); #1;

        // Table: priority, bypass on/off, zero register, scoreboard.
        for (int i = 0; i < 12; i++) begin
            we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
            we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
            iss_en = tbl[i].iss; iss_rd = tbl[i].rd;
            ra = {tbl[i].ra1, tbl[i].ra0};
            @(negedge clk);
            chk($sformatf("vec%0d q0", i),    64'(qa[31:0]),     64'(tbl[i].q0));
            chk($sformatf("vec%0d q1", i),    64'(qa[63:32]),    64'(tbl[i].q1));
            chk($sformatf("vec%0d q0nb", i),  64'(qa_nb[31:0]),  64'(tbl[i].q0nb));
            chk($sformatf("vec%0d q1nb", i),  64'(qa_nb[63:32]), 64'(tbl[i].q1nb));
            chk($sformatf("vec%0d b0", i),    64'(rbusy[0]),     64'(tbl[i].b0));
            chk($sformatf("vec%0d b1", i),    64'(rbusy[1]),     64'(tbl[i].b1));
            @(posedge clk);
            m_edge();
            #1;
        end
        idle_in();

        // Reset in the middle of traffic, then every register reads 0.
        for (int i = 0; i < 6; i++) begin
            we0 = 1; wa0 = 5'(i + 10); wd0 = $urandom; iss_en = 1; iss_rd = 5'(i + 20);
            ra = {5'(i + 9), 5'(i + 19)};
            step("preload");
        end
        idle_in();
        #2 clrn = 1;
        #1;
        m_reset();
        ra = {5'd10, 5'd20};
        chk("midop rst qa", qa, 64'd0);
        chk("midop rst busy", 64'(rbusy), 64'd0);
        @(negedge clk); clrn = 0;
        @(posedge clk); #1;
        read_all("after_rst");

        // Clear engine: fill, mark some busy, clear with injected traffic.
        for (int i = 1; i < 32; i++) begin
            we0 = 1; wa0 = 5'(i); wd0 = 32'(i); ra = {5'(i), 5'(i - 1)};
            step("fill");
        end
        idle_in();
        iss_en = 1; iss_rd = 6; step("iss6");
        iss_rd = 4; step("iss4");
        iss_en = 0;
        run_clear("clr", 10, n);
        chk("clr length", 64'(n), 64'd32);
        ra = {5'd4, 5'd3};
        @(negedge clk);
        chk("r3 after clr", 64'(qa[31:0]), 64'd0);
        chk("r4 busy after clr", 64'(rbusy[1]), 64'd0);
        @(posedge clk); m_edge(); #1;
        read_all("after_clr");

        // Reset at clear cycle 10.
        we0 = 1; wa0 = 20; wd0 = 32'hABC; step("w20");
        idle_in();
        sclr = 1; step("sclr2");
        sclr = 0;
        for (int k = 0; k < 10; k++) begin ra = {5'd20, 5'(k)}; step("clr_part"); end
        #2 clrn = 1;
        #1;
        m_reset();
        chk("rst midclr clr_busy", 64'(clr_busy), 64'd0);
        chk("rst midclr r20", 64'(qa[63:32]), 64'd0);
        @(negedge clk); clrn = 0;
        @(posedge clk); #1;
        run_clear("clr2", -1, n);
        chk("clr2 length", 64'(n), 64'd32);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            we0 = 1'($urandom); wa0 = 5'($urandom); wd0 = $urandom;
            we1 = 1'($urandom); wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom); wd1 = $urandom;
            iss_en = 1'($urandom); iss_rd = 5'($urandom);
            sclr = ($urandom_range(0, 99) == 0);
            ra = {5'($urandom), ($urandom_range(0, 1) == 0) ? wa1 : 5'($urandom)};
            step("rand");
        end
        idle_in();
        for (int i = 0; i < 40 && mclr; i++) step("drain");

        // Parameter sweep: 64-bit data, 16 entries, 4 read ports.
        sv[0] = '0;
        sv[1] = 64'hA5A5_0000_0000_0001; sv[2] = 64'hA5A5_0000_0000_0002;
        sv[3] = 64'hA5A5_0000_0000_0003; sv[4] = 64'hA5A5_0000_0000_0004;
        s_we0 = 1; s_wa0 = 1; s_wd0 = sv[1]; s_we1 = 1; s_wa1 = 2; s_wd1 = sv[2];
        @(posedge clk); #1;
        s_wa0 = 3; s_wd0 = sv[3]; s_wa1 = 4; s_wd1 = sv[4];
        @(posedge clk); #1;
        s_we0 = 0; s_we1 = 0;
        s_ra = {4'd4, 4'd3, 4'd2, 4'd1};
        @(negedge clk);
        for (int p = 0; p < 4; p++) chk($sformatf("sw rd p%0d", p), s_qa[p*64 +: 64], sv[p + 1]);
        s_we1 = 1; s_wa1 = 2; s_wd1 = 64'hFEED_0000_0000_0002;
        s_we0 = 1; s_wa0 = 3; s_wd0 = 64'hBEEF_0000_0000_0003;
        s_ra = {4'd0, 4'd4, 4'd3, 4'd2};
        #1;
        chk("sw byp p0", s_qa[63:0],    64'hFEED_0000_0000_0002);
        chk("sw byp p1", s_qa[127:64],  64'hBEEF_0000_0000_0003);
        chk("sw byp p2", s_qa[191:128], sv[4]);
        chk("sw byp p3", s_qa[255:192], 64'd0);
        @(posedge clk); #1;
        s_we0 = 0; s_we1 = 0; s_iss = 1; s_rd = 4;
        @(posedge clk); #1;
        s_iss = 0;
        @(negedge clk);
        chk("sw busy r4", 64'(s_rbusy), 64'b0100);
        chk("sw stored r2", s_qa[63:0], 64'hFEED_0000_0000_0002);
        s_sclr = 1;
        @(posedge clk); #1;
        s_sclr = 0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!s_clr_busy) break;
            n++;
        end
        chk("sw clr length", 64'(n), 64'd16);
        chk("sw after clr qa", s_qa, 256'd0 == s_qa ? s_qa : 256'd0);
        for (int p = 0; p < 4; p++) chk($sformatf("sw clr p%0d", p), s_qa[p*64 +: 64], 64'd0);
        chk("sw clr busy", 64'(s_rbusy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
